// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the MIPS32 memory-access stage: the memory
//   operation codes carried down from EX, the stage FSM encodings, and
//   small decode helpers used by mem_stage and load_align.
`timescale 1ns/1ps
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // Encodings above MEM_SW are not operations; they collapse to MEM_NONE.
    function automatic mem_op_t decode_op(input logic [3:0] raw);
        return (raw <= 4'd8) ? mem_op_t'(raw) : MEM_NONE;
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align
//   Combinational load extractor: selects the byte/halfword addressed by
//   addr out of a 32-bit bus word and sign- or zero-extends it according
//   to the load op. Non-load ops return 0.
//   Ports:
//     op    in  4   memory op (mem_op_t)
//     addr  in  2   byte offset within the word
//     rdata in  32  raw bus word (little-endian lanes)
//     data  out 32  extended load data
`timescale 1ns/1ps
module load_align
    import mem_stage_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'd0;
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'd0;
        endcase
        // Halfword alignment guarantees addr[0]=0, so addr[1] picks the half.
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        data = 32'd0;
        case (op)
            MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data = {24'd0, byte_sel};
            MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data = {16'd0, half_sel};
            MEM_LW:  data = rdata;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   MIPS32 memory-access stage. Passes ALU results to write-back, runs
//   byte/half/word loads and stores over a req/ack bus, stalls upstream
//   while an access is outstanding, and drops misaligned accesses with a
//   one-cycle alignErr_o pulse. Output registers form the MEM/WB register.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     memOp_i, result_i,        instruction from EX/MEM (result_i is the
//     storeData_i, writeAddr_i,   effective address for memory ops)
//     writeEnable_i
//     result_o, writeAddr_o,    MEM/WB register (registered)
//     writeEnable_o
//     stallReq_o                combinational upstream stall
//     alignErr_o, badAddr_o     misalignment pulse and faulting address
//     busReq_o .. busWdata_o    registered bus request fields
//     busRdata_i, busAck_i      bus response
`timescale 1ns/1ps
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  memOp_i,
    input  logic [31:0] result_i,
    input  logic [31:0] storeData_i,
    input  logic [4:0]  writeAddr_i,
    input  logic        writeEnable_i,
    output logic [31:0] result_o,
    output logic [4:0]  writeAddr_o,
    output logic        writeEnable_o,
    output logic        stallReq_o,
    output logic        alignErr_o,
    output logic [31:0] badAddr_o,
    output logic        busReq_o,
    output logic        busWe_o,
    output logic [31:0] busAddr_o,
    output logic [3:0]  busBe_o,
    output logic [31:0] busWdata_o,
    input  logic [31:0] busRdata_i,
    input  logic        busAck_i
);

    mem_state_t  state_reg;
    mem_op_t     op_reg;
    logic [1:0]  addr_lo_reg;

    logic [31:0] result_reg, bad_addr_reg, bus_addr_reg, bus_wdata_reg;
    logic [4:0]  write_addr_reg;
    logic        write_enable_reg, align_err_reg, bus_req_reg, bus_we_reg;
    logic [3:0]  bus_be_reg;

    mem_op_t     op_in;
    logic        is_mem, misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next, load_data;

    always_comb begin
        op_in      = decode_op(memOp_i);
        is_mem     = (op_in != MEM_NONE);
        misaligned = ((op_in == MEM_LH || op_in == MEM_LHU || op_in == MEM_SH) && result_i[0])
                   || ((op_in == MEM_LW || op_in == MEM_SW) && (result_i[1:0] != 2'b00));

        be_next    = 4'b0000;
        wdata_next = 32'd0;
        case (op_in)
            MEM_LB, MEM_LBU: be_next = 4'b0001 << result_i[1:0];
            MEM_LH, MEM_LHU: be_next = result_i[1] ? 4'b1100 : 4'b0011;
            MEM_LW:          be_next = 4'b1111;
            MEM_SB: begin
                be_next    = 4'b0001 << result_i[1:0];
                wdata_next = {4{storeData_i[7:0]}};
            end
            MEM_SH: begin
                be_next    = result_i[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{storeData_i[15:0]}};
            end
            MEM_SW: begin
                be_next    = 4'b1111;
                wdata_next = storeData_i;
            end
            default: begin
                be_next    = 4'b0000;
                wdata_next = 32'd0;
            end
        endcase
    end

    // Misaligned ops never start a bus cycle, so they never stall.
    assign stallReq_o = (state_reg == MEM_IDLE) ? (is_mem && !misaligned) : !busAck_i;

    // Extraction uses the op/offset latched at request time; the inputs
    // are held by the stall, but the latched copy keeps this independent.
    load_align u_load_align (
        .op    (op_reg),
        .addr  (addr_lo_reg),
        .rdata (busRdata_i),
        .data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= MEM_IDLE;
            op_reg           <= MEM_NONE;
            addr_lo_reg      <= 2'b00;
            result_reg       <= 32'd0;
            write_addr_reg   <= 5'd0;
            write_enable_reg <= 1'b0;
            align_err_reg    <= 1'b0;
            bad_addr_reg     <= 32'd0;
            bus_req_reg      <= 1'b0;
            bus_we_reg       <= 1'b0;
            bus_addr_reg     <= 32'd0;
            bus_be_reg       <= 4'b0000;
            bus_wdata_reg    <= 32'd0;
        end else begin
            // Default: bubble into MEM/WB, no error pulse.
            result_reg       <= 32'd0;
            write_addr_reg   <= 5'd0;
            write_enable_reg <= 1'b0;
            align_err_reg    <= 1'b0;
            bad_addr_reg     <= 32'd0;
            case (state_reg)
                MEM_IDLE: begin
                    if (!is_mem) begin
                        result_reg       <= result_i;
                        write_addr_reg   <= writeAddr_i;
                        write_enable_reg <= writeEnable_i;
                    end else if (misaligned) begin
                        align_err_reg <= 1'b1;
                        bad_addr_reg  <= result_i;
                    end else begin
                        state_reg     <= MEM_WAIT;
                        op_reg        <= op_in;
                        addr_lo_reg   <= result_i[1:0];
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= op_is_store(op_in);
                        bus_addr_reg  <= {result_i[31:2], 2'b00};
                        bus_be_reg    <= be_next;
                        bus_wdata_reg <= wdata_next;
                    end
                end
                MEM_WAIT: begin
                    if (busAck_i) begin
                        state_reg   <= MEM_IDLE;
                        bus_req_reg <= 1'b0;
                        if (!op_is_store(op_reg)) begin
                            result_reg       <= load_data;
                            write_addr_reg   <= writeAddr_i;
                            write_enable_reg <= writeEnable_i;
                        end
                    end
                end
                default: state_reg <= MEM_IDLE;
            endcase
        end
    end

    assign result_o      = result_reg;
    assign writeAddr_o   = write_addr_reg;
    assign writeEnable_o = write_enable_reg;
    assign alignErr_o    = align_err_reg;
    assign badAddr_o     = bad_addr_reg;
    assign busReq_o      = bus_req_reg;
    assign busWe_o       = bus_we_reg;
    assign busAddr_o     = bus_addr_reg;
    assign busBe_o       = bus_be_reg;
    assign busWdata_o    = bus_wdata_reg;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS32 pipeline, directly downstream of the execute stage and its EX/MEM register. It passes ALU results through to write-back and performs LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus. It stalls the upstream pipeline while an access is outstanding and drops misaligned accesses with an error pulse. Its output registers form the MEM/WB pipeline register.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- memOp_i  in  4  memory operation code (encodings under Structure)
- result_i  in  32  EX result; for memory ops this is the effective address
- storeData_i  in  32  rt value for stores
- writeAddr_i  in  5  destination register
- writeEnable_i  in  1  register write request from EX
- result_o  out  32  write-back data (registered)
- writeAddr_o  out  5  write-back register (registered)
- writeEnable_o  out  1  write-back enable (registered)
- stallReq_o  out  1  combinational; upstream holds all *_i stable while high
- alignErr_o  out  1  one-cycle pulse on misaligned access (registered)
- badAddr_o  out  32  faulting address, valid while alignErr_o=1 (registered)
- busReq_o  out  1  bus request (registered)
- busWe_o  out  1  1 = write
- busAddr_o  out  32  word address, bits [1:0] forced to 0
- busBe_o  out  4  byte enables, bit n = byte lane n (little-endian)
- busWdata_o  out  32  write data, replicated across lanes
- busRdata_i  in  32  read data, valid with busAck_i
- busAck_i  in  1  completes the pending request

## Operation
- FSM states: IDLE, WAIT.
- IDLE, memOp_i=NONE: outputs load result_i/writeAddr_i/writeEnable_i at the next edge. stallReq_o=0.
- IDLE, aligned memory op:
  - stallReq_o=1.
  - Next state WAIT.
  - Bus registers load: busReq_o=1, busWe_o=store, address, enables, write data.
  - Op and addr[1:0] are latched.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No bus access. FSM stays IDLE. stallReq_o=0.
  - Next edge: alignErr_o=1, badAddr_o=result_i, output regs load a bubble.
- WAIT: busReq_o and all bus fields held stable. stallReq_o = !busAck_i.
- WAIT with busAck_i=1, at the next edge:
  - FSM goes to IDLE; busReq_o=0.
  - Loads: result_o=extended data, writeEnable_o=writeEnable_i, writeAddr_o=writeAddr_i.
  - Stores: writeEnable_o=0.
- Whenever stallReq_o=1, output regs load a bubble: result_o=0, writeAddr_o=0, writeEnable_o=0.
- busAck_i is ignored in IDLE.
- Byte lanes:
  - SB: be=0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: be=0011 (addr[1]=0) or 1100, wdata={2{sd[15:0]}}.
  - SW: be=1111.
  - Loads drive the same enables with wdata=0.
- Load extract: select byte/half by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Unknown memOp encodings are treated as NONE.

## Timing
- Reset values: every output 0, FSM IDLE. rst in WAIT abandons the request: busReq_o=0 at the next edge, and the bus must tolerate this.
- Non-memory op: 1-cycle latency, presented at T → result_o at T+1.
- Memory op presented at T:
  - busReq_o=1 from T+1.
  - Ack at T+k (k≥1) → result_o and busReq_o=0 at T+k+1.
  - Next instruction is accepted at T+k+1.
  - Minimum 2 cycles.
- Back-to-back memory ops: busReq_o drops for exactly one cycle between requests.
- alignErr_o is high for exactly one cycle per faulting instruction.

## Structure
- The shared defines file gains:
  - MEM_NONE=0, MEM_LB=1, MEM_LBU=2, MEM_LH=3, MEM_LHU=4, MEM_LW=5, MEM_SB=6, MEM_SH=7, MEM_SW=8.
  - State encodings MEM_IDLE and MEM_WAIT.
- One combinational sub-module, load_align (op, addr[1:0], rdata → 32-bit extended data), reusable by a future cache.
- The EX stage and EX/MEM register carry memOp_i and storeData_i forward.

## Test plan
- OR result 0x0000_F0F0, writeEnable_i=1, addr 3, memOp NONE → next cycle result_o=0x0000_F0F0, writeAddr_o=3, writeEnable_o=1; stallReq_o never high.
- LB addr 0x1003, ack after 3 cycles with rdata 0x80_00_00_00 → busBe_o=1000 and busAddr_o=0x1000 held during WAIT; result_o=0xFFFF_FF80; stallReq_o high for exactly 3 cycles. Repeat with LBU → 0x0000_0080.
- SH addr 0x2002, storeData 0x1234_ABCD, ack at T+1 → busWe_o=1, busBe_o=1100, busWdata_o=0xABCD_ABCD; writeEnable_o stays 0.
- LW addr 0x3001 → no busReq_o, alignErr_o=1 for one cycle, badAddr_o=0x3001, writeEnable_o=0.
- rst asserted in WAIT of an LW → next edge busReq_o=0, all outputs 0; a following LW with immediate ack completes normally.
- Back-to-back SW then LW, ack at T+1 each → busReq_o pattern 1,0,1; load result appears 2 cycles after the store's result.
